// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter sharing one SECDED Hamming encoder among NUM_REQ
// requesters, with a single registered valid/ready output stage.
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_en                    grant enable (held word still drains when 0)
//   i_req_valid/i_req_data  per-requester raw data, packed NUM_REQ x DATA_WIDTH
//   o_req_ready             one-hot accept strobe to the winner
//   o_valid/i_ready         output handshake
//   o_enc_data/o_req_id     held encoded word and its requester tag
//   o_busy                  o_valid OR any request pending
//   o_stall_cnt             only with HAM_ARB_STALL_CNT_EN: saturating count of
//                           o_valid & ~i_ready cycles, cleared while i_en=0
module hamming_enc_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    localparam int ENC_WIDTH = DATA_WIDTH + $clog2(DATA_WIDTH) + 2,
    localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [ENC_WIDTH-1:0]          o_enc_data,
    output logic [ID_WIDTH-1:0]           o_req_id,
    output logic                          o_busy
`ifdef HAM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]                   o_stall_cnt
`endif
);

    // Hamming code length without the overall parity bit.
    localparam int CODE_W = ENC_WIDTH - 1;
    localparam int PAR_W  = $clog2(DATA_WIDTH) + 1;

    // Parity bits at power-of-two positions (1-based), data fills the rest
    // in order; the MSB is overall parity over the whole Hamming word.
    function automatic logic [ENC_WIDTH-1:0] ham_enc(
        input logic [DATA_WIDTH-1:0] d
    );
        logic [CODE_W-1:0] c;
        logic              p;
        int                j;
        c = '0;
        j = 0;
        for (int pos = 1; pos <= CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (j < DATA_WIDTH) c[pos-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < PAR_W; k++) begin
            p = 1'b0;
            for (int pos = 1; pos <= CODE_W; pos++) begin
                if (((pos >> k) & 1) != 0 && (pos & (pos - 1)) != 0)
                    p = p ^ c[pos-1];
            end
            c[(1 << k) - 1] = p;
        end
        return {^c, c};
    endfunction

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   win;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  found;
    logic                  grant;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        win      = '0;
        win_data = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && i_req_valid[idx]) begin
                found    = 1'b1;
                win      = ID_WIDTH'(idx);
                win_data = i_req_data[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant = i_en & found & ((state == EMPTY) | i_ready);

    always_comb begin
        o_req_ready = '0;
        if (grant) o_req_ready[win] = 1'b1;
    end

    assign o_valid = (state == FULL);
    assign o_busy  = o_valid | (|i_req_valid);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= EMPTY;
            ptr        <= '0;
            o_enc_data <= '0;
            o_req_id   <= '0;
        end else begin
            unique case (state)
                EMPTY: if (grant) state <= FULL;
                FULL:  if (i_ready && !grant) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (grant) begin
                o_enc_data <= ham_enc(win_data);
                o_req_id   <= win;
                ptr        <= ID_WIDTH'((int'(win) + 1) % NUM_REQ);
            end
        end
    end

`ifdef HAM_ARB_STALL_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (!i_en) begin
            o_stall_cnt <= '0;
        end else if (o_valid && !i_ready && o_stall_cnt != 16'hFFFF) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Bench for hamming_enc_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (syndrome-based encoder, RR search).
module tb_hamming_enc_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_en;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic        o_valid;
    logic        i_ready;
    logic [12:0] o_enc_data;
    logic [1:0]  o_req_id;
    logic        o_busy;
`ifdef HAM_ARB_STALL_CNT_EN
    logic [15:0] o_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model state
    bit        m_full;
    bit [12:0] m_enc;
    int        m_id;
    int        m_ptr;
    int        m_cnt;

    always #5 i_clk = ~i_clk;

    hamming_enc_arbiter dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_enc_data  (o_enc_data),
        .o_req_id    (o_req_id),
        .o_busy      (o_busy)
`ifdef HAM_ARB_STALL_CNT_EN
        ,
        .o_stall_cnt (o_stall_cnt)
`endif
    );

    // Codeword whose set-bit positions XOR to zero, plus overall parity.
    function automatic bit [12:0] ref_enc(input bit [7:0] d);
        bit [12:0] c;
        int j;
        int s;
        c = '0;
        j = 0;
        s = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if (pos == 1 || pos == 2 || pos == 4 || pos == 8) continue;
            if (d[j]) begin
                c[pos-1] = 1'b1;
                s = s ^ pos;
            end
            j++;
        end
        for (int k = 0; k < 4; k++)
            if (((s >> k) & 1) != 0) c[(1 << k) - 1] = 1'b1;
        c[12] = ^c[11:0];
        return c;
    endfunction

    function automatic void model_pick(output bit g, output int w);
        g = 1'b0;
        w = 0;
        if (i_en && i_req_valid != 4'b0 && (!m_full || i_ready)) begin
            for (int k = 0; k < 4; k++) begin
                int r;
                r = (m_ptr + k) % 4;
                if (i_req_valid[r]) begin
                    g = 1'b1;
                    w = r;
                    break;
                end
            end
        end
    endfunction

    function automatic bit [3:0] exp_ready();
        bit g;
        int w;
        model_pick(g, w);
        return g ? (4'b0001 << w) : 4'b0000;
    endfunction

    function automatic void model_reset();
        m_full = 1'b0;
        m_enc  = '0;
        m_id   = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endfunction

    // Commit the model for the current inputs, then step past the edge.
    task automatic advance();
        bit g;
        int w;
        model_pick(g, w);
        if (!i_en) m_cnt = 0;
        else if (m_full && !i_ready && m_cnt < 16'hFFFF) m_cnt++;
        if (g) begin
            m_enc  = ref_enc(8'(i_req_data >> (w * 8)));
            m_id   = w;
            m_full = 1'b1;
            m_ptr  = (w + 1) % 4;
        end else if (m_full && i_ready) begin
            m_full = 1'b0;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_data(input int r, input bit [7:0] d);
        i_req_data[r*8 +: 8] = d;
    endtask

    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_en        = 1'b1;
        i_ready     = 1'b1;
        i_req_valid = '0;
        i_req_data  = '0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", o_valid);
        end
        checks++;
        if (o_enc_data !== 13'h0 || o_req_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs got %h/%0d want 0/0", o_enc_data, o_req_id);
        end
        checks++;
        if (o_req_ready !== 4'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b/%b want 0000/0", o_req_ready, o_busy);
        end
    endtask

    task automatic test_single();
        i_req_valid = 4'b0001;
        set_data(0, 8'h01);
        #1;
        checks++;
        if (o_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready got %b want 0001", o_req_ready);
        end
        advance();
        i_req_valid = 4'b0000;
        checks++;
        if (o_valid !== 1'b1 || o_enc_data !== 13'h1007 || o_req_id !== 2'd0) begin
            errors++;
            $display("FAIL single_word got %b/%h/%0d want 1/1007/0",
                     o_valid, o_enc_data, o_req_id);
        end
        advance();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got %b want 0", o_valid);
        end
    endtask

    task automatic test_encode_vectors();
        i_req_valid = 4'b0100;
        set_data(2, 8'h80);
        advance();
        i_req_valid = 4'b1000;
        set_data(3, 8'h00);
        checks++;
        if (o_enc_data !== 13'h1888 || o_req_id !== 2'd2 ||
            o_enc_data !== m_enc) begin
            errors++;
            $display("FAIL enc_80 got %h/%0d want 1888/2", o_enc_data, o_req_id);
        end
        advance();
        i_req_valid = 4'b0000;
        checks++;
        if (o_valid !== 1'b1 || o_enc_data !== 13'h0000 || o_req_id !== 2'd3) begin
            errors++;
            $display("FAIL enc_00 got %b/%h/%0d want 1/0000/3",
                     o_valid, o_enc_data, o_req_id);
        end
        advance();
    endtask

    task automatic test_round_robin();
        int order[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int r = 0; r < 4; r++) set_data(r, 8'($urandom));
        i_req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            advance();
            checks++;
            if (o_valid !== 1'b1 || int'(o_req_id) != order[i] ||
                o_enc_data !== ref_enc(8'(i_req_data >> (order[i] * 8)))) begin
                errors++;
                $display("FAIL rr_%0d got %b/%0d/%h want 1/%0d/%h", i, o_valid,
                         o_req_id, o_enc_data, order[i],
                         ref_enc(8'(i_req_data >> (order[i] * 8))));
            end
        end
        i_req_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        bit [12:0] held;
        held        = o_enc_data;
        i_ready     = 1'b0;
        i_req_valid = 4'b0010;
        set_data(1, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (o_req_ready !== 4'b0 || o_valid !== 1'b1 || o_enc_data !== held) begin
                errors++;
                $display("FAIL bp_hold_%0d got %b/%b/%h want 0000/1/%h",
                         i, o_req_ready, o_valid, o_enc_data, held);
            end
            advance();
        end
`ifdef HAM_ARB_STALL_CNT_EN
        checks++;
        if (o_stall_cnt !== 16'd5 || int'(o_stall_cnt) != m_cnt) begin
            errors++;
            $display("FAIL bp_stall got %0d want 5", o_stall_cnt);
        end
`endif
        i_ready = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release got %b want 0010", o_req_ready);
        end
        advance();
        i_req_valid = 4'b0000;
        checks++;
        if (o_req_id !== 2'd1 || o_enc_data !== ref_enc(8'h5A)) begin
            errors++;
            $display("FAIL bp_word got %0d/%h want 1/%h",
                     o_req_id, o_enc_data, ref_enc(8'h5A));
        end
    endtask

    task automatic test_enable();
        // o_valid is high from the previous grant
        i_en        = 1'b0;
        i_req_valid = 4'b1011;
        #1;
        checks++;
        if (o_req_ready !== 4'b0) begin
            errors++;
            $display("FAIL en_off_ready got %b want 0000", o_req_ready);
        end
        advance();
        advance();
        checks++;
        if (o_valid !== 1'b0 || o_req_ready !== 4'b0) begin
            errors++;
            $display("FAIL en_off_drain got %b/%b want 0/0000", o_valid, o_req_ready);
        end
`ifdef HAM_ARB_STALL_CNT_EN
        checks++;
        if (o_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL en_off_cnt got %0d want 0", o_stall_cnt);
        end
`endif
        i_en = 1'b1;
        #1;
        checks++;
        // pointer was 2 after requester 1 won; next valid from 2 is 3
        if (o_req_ready !== 4'b1000 || o_req_ready !== exp_ready()) begin
            errors++;
            $display("FAIL en_resume got %b want 1000", o_req_ready);
        end
        advance();
        i_req_valid = 4'b0000;
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            i_en        = ($urandom_range(0, 7) != 0);
            i_ready     = ($urandom_range(0, 3) != 0);
            i_req_valid = 4'($urandom);
            i_req_data  = $urandom;
            #1;
            checks++;
            if (o_req_ready !== exp_ready() ||
                o_busy !== (m_full || i_req_valid != 0)) begin
                errors++;
                $display("FAIL rnd_comb_%0d got %b/%b want %b/%b", i, o_req_ready,
                         o_busy, exp_ready(), (m_full || i_req_valid != 0));
            end
            advance();
            checks++;
            if (o_valid !== m_full ||
                (m_full && (o_enc_data !== m_enc || int'(o_req_id) != m_id))) begin
                errors++;
                $display("FAIL rnd_out_%0d got %b/%h/%0d want %b/%h/%0d", i,
                         o_valid, o_enc_data, o_req_id, m_full, m_enc, m_id);
            end
`ifdef HAM_ARB_STALL_CNT_EN
            checks++;
            if (int'(o_stall_cnt) != m_cnt) begin
                errors++;
                $display("FAIL rnd_cnt_%0d got %0d want %0d", i, o_stall_cnt, m_cnt);
            end
`endif
        end
        i_en        = 1'b1;
        i_ready     = 1'b1;
        i_req_valid = 4'b0;
        advance();
    endtask

    task automatic test_async_reset();
        i_req_valid = 4'b0100;
        set_data(2, 8'hC3);
        advance();
        i_req_valid = 4'b0000;
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_enc_data !== 13'h0) begin
            errors++;
            $display("FAIL areset_drop got %b/%h want 0/0000", o_valid, o_enc_data);
        end
        model_reset();
        i_rst_n     = 1'b1;
        i_req_valid = 4'b1110;
        set_data(1, 8'h11);
        #1;
        checks++;
        if (o_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL areset_first got %b want 0010", o_req_ready);
        end
        i_req_valid = 4'b1111;
        set_data(0, 8'hF0);
        #1;
        checks++;
        if (o_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL areset_ptr got %b want 0001", o_req_ready);
        end
        advance();
        i_req_valid = 4'b0000;
        checks++;
        if (o_req_id !== 2'd0 || o_enc_data !== ref_enc(8'hF0)) begin
            errors++;
            $display("FAIL areset_word got %0d/%h want 0/%h",
                     o_req_id, o_enc_data, ref_enc(8'hF0));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_encode_vectors();
        test_round_robin();
        test_backpressure();
        test_enable();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
